// File: rtl/dram_ctrl_pkg.sv
// Shared definitions for the DRAM controller: default widths and the
// controller state encoding.
package dram_ctrl_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WADDR = 3'd1,
      ST_WHOLD = 3'd2,
      ST_WDATA = 3'd3,
      ST_RD    = 3'd4,
      ST_RWAIT = 3'd5
   } state_e;

endpackage

// File: rtl/dram_ctrl.sv
// Simple single-port DRAM controller. A write latches the address into the
// DRAM (strobe, then one hold cycle for the delayed latch) and then strobes
// the data; a read presents the address and registers the returned word.
// Optional feature macro DRAM_CTRL_ADDR_CACHE_EN: remember the last address
// latched into the DRAM so a repeat write to it can skip the address phases.
module dram_ctrl
   import dram_ctrl_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic              resp_write,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              dram_write_en,
   output logic              dram_addr_write_en,
   output logic [ADDR_W-1:0] dram_addr,
   output logic [DATA_W-1:0] dram_data_out,
   input  logic [DATA_W-1:0] dram_data_in
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              write_q, write_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic              resp_valid_q, resp_valid_d;
   logic              resp_write_q, resp_write_d;
   logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
`ifdef DRAM_CTRL_ADDR_CACHE_EN
   logic [ADDR_W-1:0] cache_addr_q, cache_addr_d;
   logic              cache_valid_q, cache_valid_d;
`endif

   // Next-state, request capture and the registered DRAM data bus.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      write_d      = write_q;
      data_out_d   = data_out_q;
      resp_valid_d = 1'b0;
      resp_write_d = resp_write_q;
      resp_rdata_d = resp_rdata_q;
`ifdef DRAM_CTRL_ADDR_CACHE_EN
      cache_addr_d  = cache_addr_q;
      cache_valid_d = cache_valid_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               addr_d  = req_addr;
               wdata_d = req_wdata;
               write_d = req_write;
               if (req_write) begin
`ifdef DRAM_CTRL_ADDR_CACHE_EN
                  if (cache_valid_q && (cache_addr_q == req_addr)) begin
                     state_d    = ST_WDATA;
                     data_out_d = req_wdata;
                  end else
`endif
                  begin
                     state_d    = ST_WADDR;
                     data_out_d = DATA_W'(req_addr);
                  end
               end else begin
                  state_d    = ST_RD;
                  data_out_d = DATA_W'(req_addr);
               end
            end
         end
         ST_WADDR: begin
            state_d = ST_WHOLD;
`ifdef DRAM_CTRL_ADDR_CACHE_EN
            cache_addr_d  = addr_q;
            cache_valid_d = 1'b1;
`endif
         end
         ST_WHOLD: begin
            state_d    = ST_WDATA;
            data_out_d = wdata_q;
         end
         ST_WDATA: begin
            state_d      = ST_IDLE;
            resp_valid_d = 1'b1;
            resp_write_d = write_q;
         end
         ST_RD: begin
            state_d = ST_RWAIT;
         end
         ST_RWAIT: begin
            state_d      = ST_IDLE;
            resp_valid_d = 1'b1;
            resp_write_d = write_q;
            resp_rdata_d = dram_data_in;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         addr_q        <= '0;
         wdata_q       <= '0;
         write_q       <= 1'b0;
         data_out_q    <= '0;
         resp_valid_q  <= 1'b0;
         resp_write_q  <= 1'b0;
         resp_rdata_q  <= '0;
`ifdef DRAM_CTRL_ADDR_CACHE_EN
         cache_addr_q  <= '0;
         cache_valid_q <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         write_q       <= write_d;
         data_out_q    <= data_out_d;
         resp_valid_q  <= resp_valid_d;
         resp_write_q  <= resp_write_d;
         resp_rdata_q  <= resp_rdata_d;
`ifdef DRAM_CTRL_ADDR_CACHE_EN
         cache_addr_q  <= cache_addr_d;
         cache_valid_q <= cache_valid_d;
`endif
      end
   end

   assign req_ready          = (state_q == ST_IDLE);
   assign dram_addr_write_en = (state_q == ST_WADDR);
   assign dram_write_en      = (state_q == ST_WDATA);
   assign dram_addr          = addr_q;
   assign dram_data_out      = data_out_q;
   assign resp_valid         = resp_valid_q;
   assign resp_write         = resp_write_q;
   assign resp_rdata         = resp_rdata_q;

endmodule

// File: tb/tb_dram_ctrl.sv
// Self-checking bench for dram_ctrl: directed scenarios plus randomized
// traffic scored against a transaction-level model (memory contents,
// expected latency, last-latched-address tracking).
module tb_dram_ctrl;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 16;
`ifdef DRAM_CTRL_ADDR_CACHE_EN
   localparam bit CACHE_ON = 1'b1;
`else
   localparam bit CACHE_ON = 1'b0;
`endif

   logic              clk;
   logic              rst;
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic              resp_write;
   logic [DATA_W-1:0] resp_rdata;
   logic              dram_write_en;
   logic              dram_addr_write_en;
   logic [ADDR_W-1:0] dram_addr;
   logic [DATA_W-1:0] dram_data_out;
   logic [DATA_W-1:0] dram_data_in;

   int vectors;
   int miscompares;
   bit running;

   dram_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk                (clk),
      .rst                (rst),
      .req_valid          (req_valid),
      .req_ready          (req_ready),
      .req_write          (req_write),
      .req_addr           (req_addr),
      .req_wdata          (req_wdata),
      .resp_valid         (resp_valid),
      .resp_write         (resp_write),
      .resp_rdata         (resp_rdata),
      .dram_write_en      (dram_write_en),
      .dram_addr_write_en (dram_addr_write_en),
      .dram_addr          (dram_addr),
      .dram_data_out      (dram_data_out),
      .dram_data_in       (dram_data_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // DRAM device model: address latched one cycle after its strobe,
   // write strobe stores to the latched address, asynchronous read port.
   logic [DATA_W-1:0] dramMem [0:(1<<ADDR_W)-1];
   logic [ADDR_W-1:0] latchedAddr;
   logic              latchPending;

   initial begin
      latchedAddr  = '0;
      latchPending = 1'b0;
      for (int i = 0; i < (1 << ADDR_W); i++) dramMem[i] = '0;
   end

   always @(posedge clk) begin
      if (dram_write_en) dramMem[latchedAddr] <= dram_data_out;
      if (latchPending) latchedAddr <= dram_data_out;
      latchPending <= dram_addr_write_en;
   end

   assign dram_data_in = dramMem[dram_data_out];

   // Reference model state
   logic [DATA_W-1:0] refMem [int];
   logic [ADDR_W-1:0] refCacheAddr;
   bit                refCacheValid;

   function automatic logic [DATA_W-1:0] refRead(input logic [ADDR_W-1:0] a);
      if (refMem.exists(int'(a))) return refMem[int'(a)];
      return '0;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Strobe exclusivity watched every cycle while the bench is active.
   always @(negedge clk) begin
      if (running) begin
         vectors++;
         assert (!(dram_write_en && dram_addr_write_en))
         else begin
            miscompares++;
            $error("[TB] FAIL strobe_excl observed=1 expected=0");
         end
      end
   end

   // One transaction. Entered and left at a negedge; leaves on the
   // response cycle so the next call is issued back-to-back.
   task automatic applyStimulus(input bit isWrite, input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] data, output int lat);
      bit                hit;
      int                expLat;
      int                k;
      logic              trAw [1:8];
      logic              trWe [1:8];
      logic [DATA_W-1:0] trDout [1:8];
      for (int i = 1; i <= 8; i++) begin
         trAw[i] = 1'bx; trWe[i] = 1'bx; trDout[i] = 'x;
      end
      hit    = isWrite && CACHE_ON && refCacheValid && (refCacheAddr == addr);
      expLat = !isWrite ? 3 : (hit ? 2 : 4);
      checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_write = isWrite;
      req_addr  = addr;
      req_wdata = data;
      k = 0;
      while (k < 8) begin
         @(negedge clk);
         k++;
         trAw[k]   = dram_addr_write_en;
         trWe[k]   = dram_write_en;
         trDout[k] = dram_data_out;
         if (resp_valid) break;
         if (k == 1) begin
            req_write = $urandom_range(0, 1) == 1;
            req_addr  = ADDR_W'($urandom);
            req_wdata = DATA_W'($urandom);
         end else begin
            req_valid = 1'b0;
         end
      end
      req_valid = 1'b0;
      lat = k;
      checkOutput("latency", 32'(k), 32'(expLat));
      checkOutput("resp_valid", 32'(resp_valid), 32'd1);
      checkOutput("resp_write", 32'(resp_write), 32'(isWrite));
      if (!isWrite) begin
         checkOutput("rdata", 32'(resp_rdata), 32'(refRead(addr)));
         checkOutput("rd_dout", 32'(trDout[1]), 32'(addr));
         checkOutput("rd_we", 32'(trWe[1]), 32'd0);
      end else if (hit) begin
         checkOutput("hit_we", 32'(trWe[1]), 32'd1);
         checkOutput("hit_dout", 32'(trDout[1]), 32'(data));
      end else begin
         checkOutput("waddr_aw", 32'(trAw[1]), 32'd1);
         checkOutput("waddr_dout", 32'(trDout[1]), 32'(addr));
         checkOutput("whold_strb", 32'({trAw[2], trWe[2]}), 32'd0);
         checkOutput("whold_dout", 32'(trDout[2]), 32'(addr));
         checkOutput("wdata_we", 32'(trWe[3]), 32'd1);
         checkOutput("wdata_dout", 32'(trDout[3]), 32'(data));
      end
      if (isWrite) begin
         refMem[int'(addr)] = data;
         if (!hit) begin
            refCacheAddr  = addr;
            refCacheValid = 1'b1;
         end
      end
   endtask

   initial begin
      int lat;
      vectors       = 0;
      miscompares   = 0;
      running       = 1'b0;
      refCacheAddr  = '0;
      refCacheValid = 1'b0;
      rst       = 1'b1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;

      repeat (3) @(negedge clk);
      $display("[TB] checking reset state");
      checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("rst_resp_write", 32'(resp_write), 32'd0);
      checkOutput("rst_resp_rdata", 32'(resp_rdata), 32'd0);
      checkOutput("rst_data_out", 32'(dram_data_out), 32'd0);
      checkOutput("rst_dram_addr", 32'(dram_addr), 32'd0);
      checkOutput("rst_strobes", 32'({dram_write_en, dram_addr_write_en}), 32'd0);
      checkOutput("rst_ready", 32'(req_ready), 32'd1);
      rst     = 1'b0;
      running = 1'b1;
      @(negedge clk);

      dramMem[40]  = 16'd23;
      refMem[40]   = 16'd23;

      $display("[TB] directed write / read / back-to-back");
      applyStimulus(1'b1, 16'd25, 16'h000C, lat);
      checkOutput("w25_lat", 32'(lat), 32'd4);
      applyStimulus(1'b0, 16'd40, 16'h0000, lat);
      checkOutput("r40_lat", 32'(lat), 32'd3);
      checkOutput("r40_data", 32'(resp_rdata), 32'd23);
      applyStimulus(1'b1, 16'd41, 16'h1234, lat);
      applyStimulus(1'b0, 16'd41, 16'h0000, lat);
      checkOutput("r41_data", 32'(resp_rdata), 32'h1234);
      @(negedge clk);
      checkOutput("resp_one_cycle", 32'(resp_valid), 32'd0);

      $display("[TB] reset during address hold");
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 16'd50;
      req_wdata = 16'hBEEF;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("abort_resp", 32'(resp_valid), 32'd0);
      checkOutput("abort_ready", 32'(req_ready), 32'd1);
      checkOutput("abort_strobes", 32'({dram_write_en, dram_addr_write_en}), 32'd0);
      checkOutput("abort_dout", 32'(dram_data_out), 32'd0);
      refCacheValid = 1'b0;
      repeat (2) begin
         @(negedge clk);
         checkOutput("abort_no_resp", 32'(resp_valid), 32'd0);
      end

`ifdef DRAM_CTRL_ADDR_CACHE_EN
      $display("[TB] address cache");
      applyStimulus(1'b1, 16'd26, 16'h1111, lat);
      checkOutput("c26a_lat", 32'(lat), 32'd4);
      applyStimulus(1'b1, 16'd26, 16'h2222, lat);
      checkOutput("c26b_lat", 32'(lat), 32'd2);
      applyStimulus(1'b1, 16'd27, 16'h3333, lat);
      checkOutput("c27_lat", 32'(lat), 32'd4);
      applyStimulus(1'b0, 16'd26, 16'h0000, lat);
      checkOutput("c26_data", 32'(resp_rdata), 32'h2222);
`endif

      $display("[TB] randomized traffic");
      for (int n = 0; n < 60; n++) begin
         bit                w;
         logic [ADDR_W-1:0] a;
         logic [DATA_W-1:0] d;
         w = $urandom_range(0, 1) == 1;
         a = ADDR_W'(100 + $urandom_range(0, 5));
         d = DATA_W'($urandom);
         applyStimulus(w, a, d, lat);
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
      @(negedge clk);
      checkOutput("final_idle", 32'(resp_valid), 32'd0);

      running = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
